fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address fetched first after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  load-use stall from the hazard unit; holds PC and the IF/ID register.
REQ-005 flush  input  1  EX-stage redirect from the hazard unit; squashes IF/ID and loads redirect_pc.
REQ-006 redirect_pc  input  32  branch/jump target, valid when flush=1; bits [1:0] ignored (forced 0).
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1 and imem_ready=0.
REQ-009 imem_ready  input  1  fetch complete this cycle; imem_rdata valid.
REQ-010 imem_rdata  input  32  fetched instruction.
REQ-011 id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
REQ-012 id_pc, id_pc4, id_instr  output  32 each  IF/ID register: PC, PC+4, instruction.

Function
REQ-013 FSM states RUN, WAIT, KILL; reset state RUN.
REQ-014 RUN: imem_req=1, imem_addr=pc; imem_ready=1 -> instruction accepted this cycle; imem_ready=0 -> WAIT.
REQ-015 WAIT: imem_req=1, address held; imem_ready=1 -> accept, return to RUN.
REQ-016 flush in WAIT with imem_ready=0 -> KILL, pc<=redirect_pc; the old request completes and its data is discarded.
REQ-017 KILL: imem_req=1, imem_addr=old address until imem_ready=1; then -> RUN, nothing accepted.
REQ-018 Accepted instruction with stall=0 and no flush -> IF/ID <= {1, pc, pc+4, imem_rdata} next edge; pc<=pc+4 (wraps modulo 2^32).
REQ-019 Accepted instruction with stall=1 -> stored in one-entry skid buffer; pc<=pc+4; imem_req=0 while skid full.
REQ-020 Skid full and stall=0 -> IF/ID loaded from skid, skid emptied; no new instruction enters IF/ID that cycle.
REQ-021 No instruction available, stall=0, no flush -> id_valid<=0 (bubble); id_pc/id_pc4/id_instr hold.
REQ-022 stall=1, flush=0 -> IF/ID holds all fields unchanged.
REQ-023 flush=1 -> id_valid<=0, skid emptied, pc<=redirect_pc regardless of stall; any instruction accepted that cycle is discarded; flush has priority over stall.
REQ-024 Latency: imem_ready=1 at edge N with stall=0 -> id_valid=1 after edge N; zero-wait sequential fetch sustains one instruction per cycle.

Reset
REQ-025 rst_n=0 at an edge: pc<=RESET_PC, state<=RUN, skid empty, id_valid<=0, id_pc/id_pc4/id_instr<=0.
REQ-026 Reset mid-WAIT or mid-KILL abandons the outstanding request; first fetch after reset is RESET_PC.
REQ-027 imem_req=0 while rst_n=0.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt (32 bits each, reset 0, saturate at all-ones), counting cycles with stall=1, flush=1, and id_valid<=0 due to REQ-021.
REQ-029 Macro undefined: those ports and their registers are absent; all other behaviour is identical.

Structure
REQ-030 Shared pipeline package: FSM state encoding (RUN=2'd0, WAIT=2'd1, KILL=2'd2), XLEN=32, INSTR_NOP=32'h0000_0000.
REQ-031 Sub-module if_id_reg holds the IF/ID fields plus valid with load/hold/clear controls; FSM, PC, and skid stay in fetch_stage.

Verification
REQ-032 Reset release, imem_ready=1 constantly -> imem_addr 0x0, 0x4, 0x8 on successive cycles; id_pc follows one cycle later with id_valid=1.
REQ-033 stall=1 for 2 cycles while streaming at pc=0x10 -> IF/ID holds id_pc=0xC; skid holds 0x10; after release, id_pc=0x10 then 0x14, no loss, no duplicate.
REQ-034 flush=1, redirect_pc=0x40 with stall=1 in the same cycle -> id_valid=0 next cycle, next imem_addr=0x40, skid empty.
REQ-035 imem_ready=0 for 3 cycles at 0x20 -> imem_addr holds 0x20, id_valid=0 bubbles; ready -> id_pc=0x20, id_instr=imem_rdata.
REQ-036 flush redirect_pc=0x80 during WAIT at 0x24 -> KILL until ready; data for 0x24 is never seen with id_valid=1; next imem_addr=0x80.
REQ-037 pc=0xFFFF_FFFC fetch -> next imem_addr=0x0; rst_n=0 mid-WAIT -> next fetch at RESET_PC, id_valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared pipeline types and constants for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with load / hold / clear controls.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc4,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic [XLEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_instr;

    // Clear only drops valid; payload fields keep their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_instr <= INSTR_NOP;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch: PC, fetch FSM, stall skid buffer, IF/ID.
//            Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt,
    output logic [XLEN-1:0] perf_bubble_cnt
`endif
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_kill_addr;
    logic            r_skid_valid;
    fetch_entry_t    r_skid;

    logic            w_req;
    logic            w_accept;
    logic            w_load;
    logic            w_bubble;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_redirect;
    logic [XLEN-1:0] w_d_pc;
    logic [XLEN-1:0] w_d_instr;

    // A full skid can only exist in RUN, so it only throttles RUN requests.
    assign w_req      = rst_n && ((r_state != RUN) || !r_skid_valid);
    assign w_accept   = w_req && imem_ready && (r_state != KILL);
    assign w_pc4      = r_pc + XLEN'(4);
    assign w_redirect = redirect_pc & ~XLEN'(3);

    assign imem_req  = w_req;
    assign imem_addr = (r_state == KILL) ? r_kill_addr : r_pc;

    assign w_load    = !flush && !stall && (r_skid_valid || w_accept);
    assign w_bubble  = !flush && !stall && !r_skid_valid && !w_accept;
    assign w_d_pc    = r_skid_valid ? r_skid.pc    : r_pc;
    assign w_d_instr = r_skid_valid ? r_skid.instr : imem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_pc         <= RESET_PC;
            r_kill_addr  <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_req && !imem_ready) begin
                        r_state <= flush ? KILL : WAIT;
                        if (flush) r_kill_addr <= r_pc;
                    end
                end
                WAIT: begin
                    if (imem_ready) begin
                        r_state <= RUN;
                    end else if (flush) begin
                        r_state     <= KILL;
                        r_kill_addr <= r_pc;
                    end
                end
                KILL: begin
                    if (imem_ready) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase

            if (flush) begin
                r_pc <= w_redirect;
            end else if (w_accept) begin
                r_pc <= w_pc4;
            end

            if (flush) begin
                r_skid_valid <= 1'b0;
            end else if (r_skid_valid && !stall) begin
                r_skid_valid <= 1'b0;
            end else if (w_accept && stall) begin
                r_skid_valid <= 1'b1;
                r_skid       <= '{pc: r_pc, instr: imem_rdata};
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (flush || w_bubble),
        .i_pc    (w_d_pc),
        .i_pc4   (w_d_pc + XLEN'(4)),
        .i_instr (w_d_instr),
        .o_valid (id_valid),
        .o_pc    (id_pc),
        .o_pc4   (id_pc4),
        .o_instr (id_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;
    logic [XLEN-1:0] r_bubble_cnt;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1))     r_stall_cnt  <= r_stall_cnt + XLEN'(1);
            if (flush && (r_flush_cnt != '1))     r_flush_cnt  <= r_flush_cnt + XLEN'(1);
            if (w_bubble && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + XLEN'(1);
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`else
    // Counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed scoreboard bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        mon_rst;
    logic        mon_stall;
    logic        mon_flush;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_instr    (id_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a new IF/ID entry appears after any edge without reset, stall or flush.
    always @(posedge clk) begin
        mon_rst   = rst_n;
        mon_stall = stall;
        mon_flush = flush;
        #1;
        if (mon_rst && !mon_stall && !mon_flush && id_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL id_unexpected: got id_pc=%h expected none", id_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("id_pc", id_pc, mon_exp);
                chk("id_pc4", id_pc4, mon_exp + 32'd4);
                chk("id_instr", id_instr, mem_word(mon_exp));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        imem_ready  = 1'b1;
        redirect_pc = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);

        // Sequential streaming from reset
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stream_addr", imem_addr, 32'(i * 4));
            exp_q.push_back(32'(i * 4));
            @(negedge clk);
        end

        // Two-cycle stall at 0x10
        chk("stall_addr", imem_addr, 32'h10);
        exp_q.push_back(32'h10);
        stall = 1'b1;
        @(negedge clk);
        chk("stall_hold_pc", id_pc, 32'hC);
        chk("stall_hold_valid", {31'b0, id_valid}, 32'd1);
        chk("skid_full_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("stall_hold_pc2", id_pc, 32'hC);
        stall = 1'b0;
        @(negedge clk);
        chk("skid_drain_pc", id_pc, 32'h10);
        chk("post_skid_addr", imem_addr, 32'h14);
        exp_q.push_back(32'h14);
        @(negedge clk);

        // Flush with simultaneous stall
        chk("pre_flush_addr", imem_addr, 32'h18);
        flush = 1'b1;
        stall = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'h40);
        chk("flush_skid_empty", {31'b0, imem_req}, 32'd1);
        flush = 1'b0;
        stall = 1'b0;
        exp_q.push_back(32'h40);
        @(negedge clk);

        // Redirect to 0x20, then three wait cycles
        flush = 1'b1;
        redirect_pc = 32'h20;
        @(negedge clk);
        flush = 1'b0;
        imem_ready = 1'b0;
        chk("wait_start_addr", imem_addr, 32'h20);
        repeat (3) begin
            @(negedge clk);
            chk("wait_addr", imem_addr, 32'h20);
            chk("wait_bubble", {31'b0, id_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        exp_q.push_back(32'h20);
        @(negedge clk);
        chk("wait_instr", id_instr, mem_word(32'h20));
        chk("after_wait_addr", imem_addr, 32'h24);

        // Flush during WAIT at 0x24
        imem_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        flush = 1'b0;
        chk("kill_addr", imem_addr, 32'h24);
        chk("kill_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        chk("kill_addr2", imem_addr, 32'h24);
        imem_ready = 1'b1;
        @(negedge clk);
        chk("kill_bubble", {31'b0, id_valid}, 32'd0);
        chk("kill_next_addr", imem_addr, 32'h80);
        exp_q.push_back(32'h80);
        @(negedge clk);

        // Wrap at top of address space; low redirect bits ignored
        flush = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        flush = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("pre_reset_addr", imem_addr, 32'h4);
        imem_ready = 1'b0;

        // Reset in the middle of WAIT at 0x4
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req_low", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("rst_wait_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_wait_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("post_rst_addr", imem_addr, 32'h4);
        exp_q.push_back(32'h4);
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
